// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared geometry, FSM state type and helpers for the
//               direct-mapped data cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  localparam int c_INDEX_W  = 4;
  localparam int c_OFFSET_W = 2;
  localparam int c_TAG_W    = 32 - c_INDEX_W - c_OFFSET_W - 2;
  localparam int c_LINES    = 1 << c_INDEX_W;
  localparam int c_WORDS    = 1 << c_OFFSET_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_REFILL = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Performance counters stick at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_tag_array.sv
`default_nettype none
// ============================================================================
// Module      : dcache_tag_array
// Description : Tag and valid storage. Asynchronous read, synchronous write,
//               valid bits cleared together on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_tag_array
  import dcache_pkg::*;
#(
  parameter int INDEX_W = c_INDEX_W,
  parameter int TAG_W   = c_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] i_ridx,
  output logic [TAG_W-1:0]   o_rtag,
  output logic               o_rvalid,
  input  logic               i_we,
  input  logic [INDEX_W-1:0] i_widx,
  input  logic [TAG_W-1:0]   i_wtag,
  input  logic               i_wvalid
);

  localparam int LINES = 1 << INDEX_W;

  logic [TAG_W-1:0] r_tags [LINES];
  logic [LINES-1:0] r_valid;

  assign o_rtag   = r_tags[i_ridx];
  assign o_rvalid = r_valid[i_widx == i_ridx && 1'b0 ? i_widx : i_ridx];

  // Valid bits: cleared on reset, updated on any tag write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= i_wvalid;
    end
  end

  // Tag contents carry no reset; a line is only trusted when its valid bit is set
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tags[i_widx] <= i_wtag;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped data cache controller. Read miss refills the
//               whole line; stores are write-through, no-write-allocate.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_W  = c_INDEX_W,
  parameter int OFFSET_W = c_OFFSET_W,
  parameter int TAG_W    = 32 - INDEX_W - OFFSET_W - 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_cpu_req,
  input  logic                        i_cpu_we,
  input  logic [31:0]                 i_cpu_addr,
  input  logic [31:0]                 i_cpu_wdata,
  output logic [31:0]                 o_cpu_rdata,
  output logic                        o_cpu_stall,
  output logic                        o_hit,
  output logic [INDEX_W+OFFSET_W-1:0] o_arr_addr,
  output logic                        o_arr_we,
  output logic [31:0]                 o_arr_wdata,
  input  logic [31:0]                 i_arr_rdata,
  output logic                        o_mem_req,
  output logic                        o_mem_we,
  output logic [31:0]                 o_mem_addr,
  output logic [31:0]                 o_mem_wdata,
  input  logic [31:0]                 i_mem_rdata,
  input  logic                        i_mem_ack,
  output logic [31:0]                 o_hit_cnt,
  output logic [31:0]                 o_miss_cnt
);

  state_t              r_state;
  logic [OFFSET_W-1:0] r_cnt;
  logic [TAG_W-1:0]    r_tag;
  logic [INDEX_W-1:0]  r_index;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [31:0]         r_hit_cnt;
  logic [31:0]         r_miss_cnt;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [OFFSET_W-1:0] w_offset;
  logic [TAG_W-1:0]    w_rtag;
  logic                w_rvalid;
  logic                w_hit;
  logic                w_ack;
  logic                w_last;
  logic                w_tag_we;
  logic [INDEX_W-1:0]  w_tag_widx;
  logic [TAG_W-1:0]    w_tag_wtag;
  logic                w_tag_wvalid;

  assign w_tag    = i_cpu_addr[31 -: TAG_W];
  assign w_index  = i_cpu_addr[OFFSET_W+2 +: INDEX_W];
  assign w_offset = i_cpu_addr[2 +: OFFSET_W];

  // An ack with no outstanding request is ignored
  assign w_ack  = i_mem_ack & r_mem_req;
  assign w_last = (r_cnt == {OFFSET_W{1'b1}});
  assign w_hit  = w_rvalid && (w_rtag == w_tag);

  assign o_hit       = w_hit;
  assign o_cpu_rdata = i_arr_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_wdata = i_cpu_wdata;
  assign o_hit_cnt   = r_hit_cnt;
  assign o_miss_cnt  = r_miss_cnt;

  dcache_tag_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tag_array (
    .clk      (clk),
    .rst      (rst),
    .i_ridx   (w_index),
    .o_rtag   (w_rtag),
    .o_rvalid (w_rvalid),
    .i_we     (w_tag_we),
    .i_widx   (w_tag_widx),
    .i_wtag   (w_tag_wtag),
    .i_wvalid (w_tag_wvalid)
  );

  // Per-state steering of stall, data array port, memory address and tag writes
  always_comb begin
    o_cpu_stall  = 1'b0;
    o_arr_we     = 1'b0;
    o_arr_addr   = {w_index, w_offset};
    o_arr_wdata  = i_cpu_wdata;
    o_mem_addr   = i_cpu_addr;
    w_tag_we     = 1'b0;
    w_tag_widx   = w_index;
    w_tag_wtag   = w_tag;
    w_tag_wvalid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cpu_req) begin
          if (i_cpu_we) begin
            // Write-through: update the array now only if the line is present
            o_cpu_stall = 1'b1;
            o_arr_we    = w_hit;
          end else if (!w_hit) begin
            // Invalidate the victim so an abandoned refill never leaves stale data
            o_cpu_stall = 1'b1;
            w_tag_we    = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        o_cpu_stall = 1'b1;
      end
      ST_REFILL: begin
        o_cpu_stall = 1'b1;
        o_arr_addr  = {r_index, r_cnt};
        o_arr_wdata = i_mem_rdata;
        o_arr_we    = w_ack;
        o_mem_addr  = {r_tag, r_index, r_cnt, 2'b00};
        if (w_ack && w_last) begin
          w_tag_we     = 1'b1;
          w_tag_widx   = r_index;
          w_tag_wtag   = r_tag;
          w_tag_wvalid = 1'b1;
        end
      end
      ST_RESP: begin
        o_cpu_stall = 1'b0;
      end
      default: begin
        o_cpu_stall = 1'b0;
      end
    endcase
  end

  // Control FSM with registered memory request, refill counter and hit/miss counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_tag      <= '0;
      r_index    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cpu_req) begin
            if (w_hit) begin
              r_hit_cnt <= sat_inc(r_hit_cnt);
            end else begin
              r_miss_cnt <= sat_inc(r_miss_cnt);
            end
            if (i_cpu_we) begin
              r_state   <= ST_WRITE;
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b1;
            end else if (!w_hit) begin
              r_state   <= ST_REFILL;
              r_tag     <= w_tag;
              r_index   <= w_index;
              r_cnt     <= '0;
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b0;
            end
          end
        end
        ST_WRITE: begin
          if (w_ack) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        ST_REFILL: begin
          if (w_ack) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state   <= ST_RESP;
              r_mem_req <= 1'b0;
            end
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Directed self-checking bench for dcache_ctrl with a data
//               array model and a variable-latency memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        hit;
  logic [5:0]  arr_addr;
  logic        arr_we;
  logic [31:0] arr_wdata;
  logic [31:0] arr_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_lat = 1;

  logic [31:0] arr_mem [64];
  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] q_maddr [$];
  logic        q_mwe [$];
  logic [31:0] q_mwdata [$];
  logic [5:0]  q_aaddr [$];
  logic [31:0] q_adata [$];

  dcache_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_cpu_req   (cpu_req),
    .i_cpu_we    (cpu_we),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_stall (cpu_stall),
    .o_hit       (hit),
    .o_arr_addr  (arr_addr),
    .o_arr_we    (arr_we),
    .o_arr_wdata (arr_wdata),
    .i_arr_rdata (arr_rdata),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_ack   (mem_ack),
    .o_hit_cnt   (hit_cnt),
    .o_miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  // External data array: async read, sync write
  assign arr_rdata = arr_mem[arr_addr];
  always @(posedge clk) begin
    if (arr_we) arr_mem[arr_addr] <= arr_wdata;
  end

  // Log every data array write seen mid-cycle
  always @(negedge clk) begin
    if (arr_we && !rst) begin
      q_aaddr.push_back(arr_addr);
      q_adata.push_back(arr_wdata);
    end
  end

  // Memory: ack in the ack_lat-th cycle a request is held; unwritten words read as C0DE_xxxx
  initial begin
    int wcnt;
    wcnt      = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req && !rst) begin
        wcnt++;
        if (wcnt >= ack_lat) begin
          wcnt    = 0;
          mem_ack = 1'b1;
          q_maddr.push_back(mem_addr);
          q_mwe.push_back(mem_we);
          q_mwdata.push_back(mem_wdata);
          if (mem_we) mem_store[mem_addr] = mem_wdata;
          else if (mem_store.exists(mem_addr)) mem_rdata = mem_store[mem_addr];
          else mem_rdata = 32'hC0DE_0000 | mem_addr;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clear_logs();
    q_maddr.delete();
    q_mwe.delete();
    q_mwdata.delete();
    q_aaddr.delete();
    q_adata.delete();
  endtask

  // One CPU access starting at posedge+1; stores complete on the mem write ack,
  // loads when stall drops. Returns at posedge+1 with req released.
  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int stalls, output logic first_hit);
    int   cyc;
    logic done;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    stalls    = 0;
    rdata     = '0;
    done      = 1'b0;
    cyc       = 0;
    @(negedge clk);
    first_hit = hit;
    while (!done && cyc < 200) begin
      if (we) begin
        if (cpu_stall) stalls++;
        if (mem_ack && mem_req && mem_we) done = 1'b1;
      end else begin
        if (cpu_stall) stalls++;
        else begin
          rdata = cpu_rdata;
          done  = 1'b1;
        end
      end
      cyc++;
      if (!done) @(negedge clk);
    end
    check("access_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          st;
    logic        fh;
    int          acks;
    int          cyc;

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_memreq", {31'd0, mem_req}, 32'd0);
    check("rst_arrwe", {31'd0, arr_we}, 32'd0);
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_hitcnt", hit_cnt, 32'd0);
    check("rst_misscnt", miss_cnt, 32'd0);
    @(posedge clk); #1;

    // Cold read miss, ack on the second cycle of each word
    begin
      logic [31:0] exp_a [4];
      exp_a = '{32'h40, 32'h44, 32'h48, 32'h4C};
      ack_lat = 2;
      clear_logs();
      cpu_access(1'b0, 32'h40, 32'h0, rd, st, fh);
      check("cold_hit", {31'd0, fh}, 32'd0);
      check("cold_data", rd, 32'hC0DE_0040);
      check("cold_stalls", st, 32'd9);
      check("cold_nmem", q_maddr.size(), 32'd4);
      check("cold_narr", q_aaddr.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
        if (i < q_maddr.size()) begin
          check("cold_maddr", q_maddr[i], exp_a[i]);
          check("cold_mwe", {31'd0, q_mwe[i]}, 32'd0);
        end
        if (i < q_aaddr.size()) begin
          check("cold_aaddr", {26'd0, q_aaddr[i]}, 32'd16 + i);
          check("cold_adata", q_adata[i], 32'hC0DE_0040 + 32'(4 * i));
        end
      end
      @(negedge clk);
      check("cold_misscnt", miss_cnt, 32'd1);
      check("cold_hitcnt", hit_cnt, 32'd0);
      @(posedge clk); #1;
    end

    // Warm read hit: no stall, no memory traffic
    clear_logs();
    cpu_access(1'b0, 32'h48, 32'h0, rd, st, fh);
    check("warm_hit", {31'd0, fh}, 32'd1);
    check("warm_stalls", st, 32'd0);
    check("warm_data", rd, 32'hC0DE_0048);
    check("warm_nmem", q_maddr.size(), 32'd0);
    check("warm_hitcnt", hit_cnt, 32'd1);

    // Store hit, ack after 3 cycles
    ack_lat = 3;
    clear_logs();
    cpu_access(1'b1, 32'h44, 32'hDEAD_BEEF, rd, st, fh);
    check("sth_hit", {31'd0, fh}, 32'd1);
    check("sth_stalls", st, 32'd4);
    check("sth_narr", q_aaddr.size(), 32'd1);
    if (q_aaddr.size() > 0) begin
      check("sth_aaddr", {26'd0, q_aaddr[0]}, 32'd17);
      check("sth_adata", q_adata[0], 32'hDEAD_BEEF);
    end
    check("sth_nmem", q_maddr.size(), 32'd1);
    if (q_maddr.size() > 0) begin
      check("sth_maddr", q_maddr[0], 32'h44);
      check("sth_mwe", {31'd0, q_mwe[0]}, 32'd1);
      check("sth_mwdata", q_mwdata[0], 32'hDEAD_BEEF);
    end
    check("sth_hitcnt", hit_cnt, 32'd2);
    cpu_access(1'b0, 32'h44, 32'h0, rd, st, fh);
    check("ld44_hit", {31'd0, fh}, 32'd1);
    check("ld44_data", rd, 32'hDEAD_BEEF);

    // Store miss: memory write only, no allocate
    ack_lat = 1;
    clear_logs();
    cpu_access(1'b1, 32'h400, 32'h1234_5678, rd, st, fh);
    check("stm_hit", {31'd0, fh}, 32'd0);
    check("stm_narr", q_aaddr.size(), 32'd0);
    check("stm_nmem", q_maddr.size(), 32'd1);
    if (q_maddr.size() > 0) check("stm_maddr", q_maddr[0], 32'h400);
    check("stm_misscnt", miss_cnt, 32'd2);
    clear_logs();
    cpu_access(1'b0, 32'h400, 32'h0, rd, st, fh);
    check("ld400_hit", {31'd0, fh}, 32'd0);
    check("ld400_data", rd, 32'h1234_5678);
    check("ld400_stalls", st, 32'd5);
    check("ld400_nmem", q_maddr.size(), 32'd4);
    check("ld400_misscnt", miss_cnt, 32'd3);

    // Conflict: 0x40 and 0x440 share index 4
    cpu_access(1'b0, 32'h40, 32'h0, rd, st, fh);
    check("cf1_hit", {31'd0, fh}, 32'd1);
    clear_logs();
    cpu_access(1'b0, 32'h440, 32'h0, rd, st, fh);
    check("cf2_hit", {31'd0, fh}, 32'd0);
    check("cf2_data", rd, 32'hC0DE_0440);
    check("cf2_nmem", q_maddr.size(), 32'd4);
    clear_logs();
    cpu_access(1'b0, 32'h40, 32'h0, rd, st, fh);
    check("cf3_hit", {31'd0, fh}, 32'd0);
    check("cf3_data", rd, 32'hC0DE_0040);
    check("cf3_nmem", q_maddr.size(), 32'd4);
    cpu_access(1'b0, 32'h44, 32'h0, rd, st, fh);
    check("cf4_data", rd, 32'hDEAD_BEEF);
    check("cf_hitcnt", hit_cnt, 32'd5);
    check("cf_misscnt", miss_cnt, 32'd5);

    // Reset in the middle of a refill
    ack_lat = 2;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h800;
    acks = 0; cyc = 0;
    while (acks < 2 && cyc < 100) begin
      @(negedge clk);
      if (mem_ack && mem_req) acks++;
      cyc++;
    end
    check("mid_acks", acks, 32'd2);
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    check("mid_memreq", {31'd0, mem_req}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_stall", {31'd0, cpu_stall}, 32'd0);
    check("mid_hitcnt", hit_cnt, 32'd0);
    check("mid_misscnt", miss_cnt, 32'd0);
    @(posedge clk); #1;
    cpu_access(1'b0, 32'h40, 32'h0, rd, st, fh);
    check("post_hit40", {31'd0, fh}, 32'd0);
    cpu_access(1'b0, 32'h800, 32'h0, rd, st, fh);
    check("post_hit800", {31'd0, fh}, 32'd0);
    check("post_data800", rd, 32'hC0DE_0800);
    check("post_misscnt", miss_cnt, 32'd2);
    check("post_hitcnt", hit_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Controller for the direct-mapped data cache data array. Owns the tag/valid arrays and sequences the external data array (cache_data) and backing memory.
- Read policy: refill on read miss.
- Write policy: write-through, no-write-allocate.
- Sits between the CPU memory stage and main memory. Stalls the CPU while a refill or write-through is in progress.

Parameters:
- INDEX_W, 4, log2 of the number of cache lines (16 lines).
- OFFSET_W, 2, log2 of the words per line (4 words).
- TAG_W, 32-INDEX_W-OFFSET_W-2, tag width. Address bits [1:0] are the byte offset and are ignored.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  CPU access valid this cycle
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address, word aligned
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data; equals arr_rdata
- cpu_stall  out  1  CPU must hold req/we/addr/wdata stable while high
- hit  out  1  combinational lookup result for cpu_addr: valid && tag match
- arr_addr  out  INDEX_W+OFFSET_W  data array word address
- arr_we  out  1  data array write enable
- arr_wdata  out  32  data array write data
- arr_rdata  in  32  data array asynchronous read data
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  32  word-aligned memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  transfer presented this cycle completes
- hit_cnt  out  32  count of CPU accesses that hit; saturating
- miss_cnt  out  32  count of CPU accesses that missed; saturating

Behaviour:
- Address split: tag = addr[31:OFFSET_W+INDEX_W+2], index = next INDEX_W bits, offset = next OFFSET_W bits.
- Reset (synchronous):
  - state = IDLE; all valid bits = 0; refill counter = 0; hit_cnt = miss_cnt = 0.
  - mem_req = 0, arr_we = 0, cpu_stall = 0.
  - Tag contents are don't-care.
  - Reset mid-refill or mid-write abandons the memory transfer: mem_req is low the cycle after rst is sampled. The line being refilled stays invalid.
- States: IDLE, WRITE, REFILL, RESP.
- IDLE:
  - arr_addr = {index, offset}.
  - Load hit: cpu_stall = 0; data is returned combinationally (0 added latency).
  - Load miss:
    - cpu_stall = 1; miss_cnt++.
    - Latch line address; counter = 0; go to REFILL.
  - Store, hit or miss:
    - cpu_stall = 1; hit_cnt or miss_cnt++ per hit.
    - Go to WRITE; mem_req asserts in WRITE.
    - If hit: arr_we = 1 this cycle with arr_wdata = cpu_wdata.
- WRITE:
  - mem_req = mem_we = 1; mem_addr = cpu_addr; mem_wdata = cpu_wdata; cpu_stall = 1.
  - On mem_ack, go to IDLE. cpu_stall is low in that IDLE cycle only if the CPU presents a new request that hits.
  - Store hit or miss does not change tag/valid.
- REFILL:
  - mem_req = 1, mem_we = 0; mem_addr = {tag, index, counter, 2'b00}.
  - On mem_ack:
    - arr_we = 1, arr_addr = {index, counter}, arr_wdata = mem_rdata.
    - counter++.
    - mem_req may stay high; the address advances the next cycle.
  - Valid is cleared on REFILL entry.
  - On the ack of the last word (counter = 2^OFFSET_W-1): write tag, set valid, go to RESP.
- RESP:
  - arr_addr = {index, offset}; cpu_rdata is valid; cpu_stall = 0.
  - Go to IDLE. The CPU consumes the data this cycle and must advance its request. hit_cnt does not increment in RESP.
- Counting rule: each CPU access counts exactly once, on its first IDLE cycle. Counters saturate at 32'hFFFF_FFFF (no wrap).
- Read-miss latency: (sum of ack waits) + 1 IDLE cycle + 1 RESP cycle.
- Output rules:
  - mem_ack while mem_req = 0 is ignored.
  - hit is combinational in every state; it is only meaningful in IDLE.
  - cpu_req = 0 in IDLE: no action, no count.

Decomposition:
- Shared package dcache_pkg:
  - State enum (IDLE/WRITE/REFILL/RESP).
  - Address-field widths and localparams (TAG_W, LINES, WORDS).
- One natural sub-module: dcache_tag_array. It holds the tag/valid storage, gives an asynchronous read, and has synchronous write and synchronous clear-all on rst.
- The FSM, refill counter and performance counters stay in dcache_ctrl.

Test Plan:
- Cold read: rst, then load 0x0000_0040, mem_ack one cycle after each req. Expect:
  - 4 reads at 0x40, 0x44, 0x48, 0x4C;
  - arr writes at addresses 16..19;
  - RESP returns mem data of 0x40;
  - miss_cnt = 1.
- Warm read: then load 0x0000_0048. Expect cpu_stall = 0, hit = 1, data = refilled word 2, hit_cnt = 1, no mem_req.
- Store hit: store 0xDEADBEEF to 0x44. Expect arr_we in IDLE and mem write at 0x44 held until ack (ack delayed 3 cycles, stall 4 cycles). A later load of 0x44 hits with 0xDEADBEEF.
- Store miss, no allocate: store to 0x400. Expect a mem write only, no arr_we. A load of 0x400 then misses and refills.
- Conflict: load 0x40, then 0x440 (same index, different tag). Expect a refill on each access; the second load evicts the first line.
- Reset mid-refill: assert rst after the 2nd ack of a refill. Expect mem_req = 0 next cycle, all misses afterwards, counters = 0.
